// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer
//
// Parallel-in/serial-out frame serializer. On LOAD it captures a frame of NUM_CH
// words of WIDTH bits from DIN. It then presents the words one per valid/ready
// handshake on DOUT, with DIN[0] first. A one-frame shadow buffer lets back-to-back
// frames stream with no idle cycles. A frame that arrives while both the main
// register and the shadow are occupied is dropped, and the sticky OVERRUN flag is set.
//
// Ports
//   CLK        : clock, rising edge
//   nRST       : asynchronous active-low reset
//   LOAD       : frame strobe, captures DIN on the rising edge where it is high
//   DIN        : parallel frame, DIN[0] sent first
//   DOUT       : current output word
//   DOUT_VALID : DOUT holds a word
//   DOUT_READY : consumer accepts the word when DOUT_VALID && DOUT_READY
//   DOUT_CH    : channel index of DOUT
//   DOUT_LAST  : DOUT is the final word of its frame
//   BUSY       : a frame sits in the main register or the shadow buffer
//   OVERRUN    : sticky, set when a frame is dropped
//   CLR_OVR    : synchronous clear of OVERRUN (a drop in the same cycle wins)

module piso_frame_serializer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 64,
    localparam int unsigned CW    = $clog2(NUM_CH)
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           LOAD,
    input  logic [NUM_CH-1:0][WIDTH-1:0]   DIN,
    output logic [WIDTH-1:0]               DOUT,
    output logic                           DOUT_VALID,
    input  logic                           DOUT_READY,
    output logic [CW-1:0]                  DOUT_CH,
    output logic                           DOUT_LAST,
    output logic                           BUSY,
    output logic                           OVERRUN,
    input  logic                           CLR_OVR
);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e                         state_q, state_d;
    logic [NUM_CH-1:0][WIDTH-1:0]   main_q, main_d;
    logic [CW-1:0]                  idx_q, idx_d;
    logic [NUM_CH-1:0][WIDTH-1:0]   shd_q, shd_d;
    logic                           shd_full_q, shd_full_d;
    logic                           ovr_q, ovr_d;

    logic is_last;
    logic accept;
    logic eof;
    logic drop;

    assign is_last = (idx_q == CW'(NUM_CH - 1));
    assign accept  = (state_q == StShift) && DOUT_READY;
    assign eof     = accept && is_last;

    // State register. The datapath registers are kept here as well.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            main_q     <= '0;
            idx_q      <= '0;
            shd_q      <= '0;
            shd_full_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            idx_q      <= idx_d;
            shd_q      <= shd_d;
            shd_full_q <= shd_full_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        main_d     = main_q;
        idx_d      = idx_q;
        shd_d      = shd_q;
        shd_full_d = shd_full_q;
        drop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (LOAD) begin
                    main_d  = DIN;
                    idx_d   = '0;
                    state_d = StShift;
                end
            end

            StShift: begin
                if (accept && !is_last) begin
                    idx_d = idx_q + CW'(1);
                end else if (eof) begin
                    // idx returns to 0 on every EOF so DOUT_CH/DOUT_LAST read 0 when idle.
                    idx_d = '0;
                    if (shd_full_q) begin
                        main_d     = shd_q;
                        shd_full_d = 1'b0;
                        // The freed shadow slot takes a LOAD arriving on the same edge.
                        if (LOAD) begin
                            shd_d      = DIN;
                            shd_full_d = 1'b1;
                        end
                    end else if (LOAD) begin
                        main_d = DIN;
                    end else begin
                        state_d = StIdle;
                    end
                end

                // A LOAD that is not absorbed at EOF goes to the shadow or is dropped.
                // When the shadow is already full, the oldest pending frame is kept.
                if (LOAD && !eof) begin
                    if (!shd_full_q) begin
                        shd_d      = DIN;
                        shd_full_d = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A drop in the same cycle beats CLR_OVR, so OVERRUN stays set.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (CLR_OVR) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Outputs are decoded from registers only.
    always_comb begin
        DOUT_VALID = (state_q == StShift);
        DOUT       = main_q[idx_q];
        DOUT_CH    = idx_q;
        DOUT_LAST  = is_last;
        BUSY       = (state_q == StShift) || shd_full_q;
        OVERRUN    = ovr_q;
    end

endmodule

// File: doc/piso_frame_serializer.md
# piso_frame_serializer

Parametrised parallel-in/serial-out frame serializer for the ADC data acquisition path. It captures a frame of `NUM_CH` sample words of `WIDTH` bits on a load strobe and presents them one word per handshake on a valid/ready output. It holds one frame in a shadow buffer so that back-to-back frames stream without bubbles, and it flags frames it had to drop. It sits between the multi-channel ADC capture stage and the single-word downstream consumer (FIFO or packetiser).

## Interface
- `NUM_CH`, 4: words per frame. Must be ≥ 2.
- `WIDTH`, 64: bits per word.
- `CLK` in 1: single clock; all logic is rising-edge.
- `nRST` in 1: asynchronous, active-low reset.
- `LOAD` in 1: frame strobe; captures `DIN` on the rising edge where it is high.
- `DIN` in [NUM_CH-1:0][WIDTH-1:0]: parallel frame. `DIN[0]` is sent first.
- `DOUT` out WIDTH: current output word.
- `DOUT_VALID` out 1: `DOUT` holds a word.
- `DOUT_READY` in 1: the consumer accepts the word when `DOUT_VALID && DOUT_READY`.
- `DOUT_CH` out CW = $clog2(NUM_CH): channel index of `DOUT`.
- `DOUT_LAST` out 1: high with the final word of a frame (`DOUT_CH == NUM_CH-1`).
- `BUSY` out 1: a frame is in the shift register or the shadow buffer.
- `OVERRUN` out 1: sticky; set when a frame is dropped.
- `CLR_OVR` in 1: synchronous clear of `OVERRUN`.

## Operation
- Storage:
  - main register: NUM_CH words plus index `idx`;
  - shadow buffer: NUM_CH words plus flag `shd_full`.
- States:
  - IDLE: main register empty, `DOUT_VALID = 0`.
  - SHIFT: main register holds a frame, `DOUT_VALID = 1`.
- Outputs are driven from the main register and `idx`: `DOUT = main[idx]`, `DOUT_CH = idx`, `DOUT_LAST = (idx == NUM_CH-1)`.
- IDLE + LOAD: copy `DIN` into main, set `idx = 0`, go to SHIFT.
- SHIFT, handshake on a non-last word: `idx` increments by 1.
- SHIFT, handshake on the last word (end-of-frame, EOF):
  - if `shd_full`: move shadow to main, set `idx = 0`, clear `shd_full`, stay in SHIFT;
  - otherwise, with LOAD in the same cycle: `DIN` goes straight to main, `idx = 0`, stay in SHIFT;
  - otherwise: go to IDLE.
- SHIFT + LOAD, not absorbed at EOF:
  - if shadow empty: `DIN` goes to shadow, `shd_full = 1`;
  - if shadow full: `DIN` is dropped, `OVERRUN = 1`, shadow is unchanged (the oldest pending frame wins).
- EOF with shadow full + LOAD in the same cycle: shadow moves to main and `DIN` goes to shadow. No overrun.
- `DOUT_VALID` low: `DOUT_READY` is ignored.
- Stall (`DOUT_READY` low while valid): `DOUT`, `DOUT_CH` and `DOUT_LAST` hold stable.
- `BUSY = DOUT_VALID | shd_full`.
- `CLR_OVR`:
  - clears `OVERRUN` next edge;
  - a drop in the same cycle takes priority, so `OVERRUN` stays 1.

## Timing
- Reset (async assert, sync deassert externally assumed by the system):
  - `DOUT = 0`, `DOUT_VALID = 0`, `DOUT_CH = 0`, `DOUT_LAST = 0`, `BUSY = 0`, `OVERRUN = 0`;
  - shadow cleared, state IDLE.
- Reset mid-frame: the frame and the shadow are discarded immediately. No partial output after release.
- Load latency: LOAD sampled at edge k gives `DOUT_VALID = 1`, `DOUT = DIN[0]` after edge k (one cycle).
- Throughput: with `DOUT_READY` held high, one word per cycle. Frame period is NUM_CH cycles.
- Back-to-back frames (shadow or same-cycle LOAD at EOF): the next frame's word 0 follows the previous last word with zero idle cycles.
- All outputs are registered or decoded from registers only. No combinational path from `DOUT_READY` or `LOAD` to any output.
- `DIN` only has to be stable in the LOAD cycle.

## Test plan
- **Basic frame:**
  - stimulus: reset 40 ns, then LOAD with DIN = {0xD,0xC,0xB,0xA} (DIN[0] = 0xA), READY = 1;
  - response: DOUT 0xA,0xB,0xC,0xD on 4 consecutive cycles, DOUT_CH 0..3, LAST only on 0xD, then VALID = 0 and BUSY = 0.
- **Backpressure:**
  - stimulus: same frame, READY low for 3 cycles while word 0xB is shown;
  - response: DOUT holds 0xB with CH = 1 for those cycles, no word lost or duplicated.
- **Back-to-back:**
  - stimulus: LOAD frame A (0xA..0xD), then LOAD frame B (0x1..0x4) two cycles later, READY = 1;
  - response: 8 consecutive valid cycles 0xA,0xB,0xC,0xD,0x1,0x2,0x3,0x4; OVERRUN = 0.
- **Overrun:**
  - stimulus: READY = 0, LOAD frames A, B, C on successive cycles, then READY = 1;
  - response: A then B are output, C is never output, OVERRUN = 1 from the C cycle onward; CLR_OVR pulse returns it to 0.
- **Same-cycle EOF + LOAD:**
  - stimulus: LOAD frame B in the exact cycle 0xD (LAST) is accepted, shadow empty;
  - response: 0x1 is valid the next cycle, no gap, OVERRUN = 0.
- **Reset mid-frame:**
  - stimulus: nRST low while DOUT = 0xB, shadow full;
  - response: all outputs go to 0 asynchronously; after release, VALID stays 0 until a new LOAD.
